// File: rtl/wta_aer.sv
// Winner-take-all arbiter and address-event encoder with lateral inhibition and a show-ahead event FIFO.
// Define WTA_AER_TIMESTAMP_EN to build the timestamp counter and per-event timestamp storage.
module wta_aer #(
    parameter int NEURONS      = 25,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int INHIB_CYCLES = 3,
    parameter int TS_W         = 16
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [NEURONS-1:0] spikes,
    output logic               latinhib,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [ADDR_W-1:0]  ev_addr,
    output logic [TS_W-1:0]    ev_ts,
    output logic [7:0]         drop_cnt,
    output logic               busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int POP_W = $clog2(NEURONS + 1);
    localparam int SUM_W = POP_W + 9;
    localparam int IC_W  = (INHIB_CYCLES > 1) ? $clog2(INHIB_CYCLES) : 1;

    localparam logic [IC_W-1:0]  INHIB_LOAD = IC_W'(INHIB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_INHIBIT = 1'b1;

    function automatic logic [POP_W-1:0] popcount(input logic [NEURONS-1:0] v);
        logic [POP_W-1:0] c;
        c = {POP_W{1'b0}};
        for (int i = 0; i < NEURONS; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [ADDR_W-1:0] lowest_index(input logic [NEURONS-1:0] v);
        logic [ADDR_W-1:0] idx;
        idx = {ADDR_W{1'b0}};
        for (int i = NEURONS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ADDR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [0:0]        state_r, state_nx_s;
    logic [IC_W-1:0]   icnt_r, icnt_nx_s;
    logic              latinhib_r, latinhib_nx_s;
    logic [7:0]        drop_cnt_r, drop_cnt_nx_s;
    logic [CNT_W-1:0]  count_r, count_nx_s;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic              valid_r, busy_r;
    logic [ADDR_W-1:0] head_addr_r, head_addr_nx_s;
    logic [ADDR_W-1:0] mem_addr_r [DEPTH];

    logic              any_s, pop_s, push_req_s, push_s, load_new_s, load_next_s;
    logic [ADDR_W-1:0] winner_s;
    logic [SUM_W-1:0]  drop_s, sum_s;

    assign any_s    = |spikes;
    assign winner_s = lowest_index(spikes);
    assign pop_s    = valid_r & ev_ready;

    // Arbitration, inhibit sequencing and per-cycle drop accounting.
    always_comb begin
        state_nx_s    = state_r;
        icnt_nx_s     = icnt_r;
        latinhib_nx_s = latinhib_r;
        push_req_s    = 1'b0;
        drop_s        = {SUM_W{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (any_s) begin
                    state_nx_s    = S_INHIBIT;
                    icnt_nx_s     = INHIB_LOAD;
                    latinhib_nx_s = 1'b1;
                    push_req_s    = 1'b1;
                    drop_s        = SUM_W'(popcount(spikes)) - SUM_W'(1);
                end else begin
                    latinhib_nx_s = 1'b0;
                end
            end
            S_INHIBIT: begin
                drop_s = SUM_W'(popcount(spikes));
                if (icnt_r == {IC_W{1'b0}}) begin
                    state_nx_s    = S_IDLE;
                    latinhib_nx_s = 1'b0;
                end else begin
                    icnt_nx_s     = icnt_r - IC_W'(1);
                    latinhib_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s    = S_IDLE;
                icnt_nx_s     = {IC_W{1'b0}};
                latinhib_nx_s = 1'b0;
            end
        endcase

        // A full FIFO still accepts when the head leaves on the same edge.
        push_s = push_req_s & ((count_r < DEPTH_C) | pop_s);
        if (push_req_s & ~push_s) begin
            drop_s = drop_s + SUM_W'(1);
        end else begin
            drop_s = drop_s;
        end

        sum_s = SUM_W'(drop_cnt_r) + drop_s;
        if (sum_s > SUM_W'(255)) begin
            drop_cnt_nx_s = 8'hFF;
        end else begin
            drop_cnt_nx_s = sum_s[7:0];
        end
    end

    // FIFO occupancy and head-register selection.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CNT_W'(1);
            2'b01:   count_nx_s = count_r - CNT_W'(1);
            default: count_nx_s = count_r;
        endcase

        load_new_s  = push_s & ((count_r == {CNT_W{1'b0}}) | (pop_s & (count_r == CNT_W'(1))));
        load_next_s = pop_s & (count_r > CNT_W'(1));

        if (load_new_s) begin
            head_addr_nx_s = winner_s;
        end else if (load_next_s) begin
            head_addr_nx_s = mem_addr_r[rd_ptr_r + PTR_ONE];
        end else begin
            head_addr_nx_s = head_addr_r;
        end
    end

    // Control, status and head registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_r     <= S_IDLE;
            icnt_r      <= {IC_W{1'b0}};
            latinhib_r  <= 1'b0;
            drop_cnt_r  <= 8'd0;
            count_r     <= {CNT_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            head_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            icnt_r      <= icnt_nx_s;
            latinhib_r  <= latinhib_nx_s;
            drop_cnt_r  <= drop_cnt_nx_s;
            count_r     <= count_nx_s;
            wr_ptr_r    <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r    <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            valid_r     <= (count_nx_s != {CNT_W{1'b0}});
            busy_r      <= (state_nx_s == S_INHIBIT) | (count_nx_s != {CNT_W{1'b0}});
            head_addr_r <= head_addr_nx_s;
        end
    end

    // Event address storage; contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_addr_r[wr_ptr_r] <= winner_s;
        end else begin
            mem_addr_r[wr_ptr_r] <= mem_addr_r[wr_ptr_r];
        end
    end

`ifdef WTA_AER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r, head_ts_r, head_ts_nx_s;
    logic [TS_W-1:0] mem_ts_r [DEPTH];

    // Head timestamp follows the same selection as the head address.
    always_comb begin
        if (load_new_s) begin
            head_ts_nx_s = ts_r;
        end else if (load_next_s) begin
            head_ts_nx_s = mem_ts_r[rd_ptr_r + PTR_ONE];
        end else begin
            head_ts_nx_s = head_ts_r;
        end
    end

    // Free-running timestamp and head timestamp register.
    always_ff @(posedge clk) begin
        if (rstb) begin
            ts_r      <= {TS_W{1'b0}};
            head_ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r      <= ts_r + TS_W'(1);
            head_ts_r <= head_ts_nx_s;
        end
    end

    // Event timestamp storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_ts_r[wr_ptr_r] <= ts_r;
        end else begin
            mem_ts_r[wr_ptr_r] <= mem_ts_r[wr_ptr_r];
        end
    end

    assign ev_ts = head_ts_r;
`else
    assign ev_ts = {TS_W{1'b0}};
`endif

    assign latinhib = latinhib_r;
    assign ev_valid = valid_r;
    assign ev_addr  = head_addr_r;
    assign drop_cnt = drop_cnt_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_wta_aer.sv
// Self-checking bench for wta_aer: per-cycle vector table plus hand-written FIFO/reset sequences,
// with a scoreboard queue of expected events compared against the FIFO head.
module tb_wta_aer;

    localparam int N = 25;

    typedef struct {
        logic [N-1:0] spk;
        logic         rdy;
        int           push;
        logic         lat;
        int           drop;
    } vec_t;

    typedef struct {
        int          addr;
        logic [15:0] ts;
    } ev_t;

    logic         clk;
    logic         rstb;
    logic [N-1:0] spikes;
    logic         latinhib;
    logic         ev_valid;
    logic         ev_ready;
    logic [4:0]   ev_addr;
    logic [15:0]  ev_ts;
    logic [7:0]   drop_cnt;
    logic         busy;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           d = 0;
    logic [15:0]  ts_now = 16'd0;
    int           last_addr = 0;
    logic [15:0]  last_ts = 16'd0;
    ev_t          exp_q[$];
    vec_t         vecs[$];
    logic [N-1:0] one;

    wta_aer dut (
        .clk      (clk),
        .rstb     (rstb),
        .spikes   (spikes),
        .latinhib (latinhib),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_addr  (ev_addr),
        .ev_ts    (ev_ts),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_ts(input logic [15:0] t);
`ifdef WTA_AER_TIMESTAMP_EN
        return t;
`else
        return 16'd0;
`endif
    endfunction

    task automatic add(input logic [N-1:0] spk, input logic rdy, input int push, input logic lat,
                       input int drop);
        vec_t v;
        v.spk = spk; v.rdy = rdy; v.push = push; v.lat = lat; v.drop = drop;
        vecs.push_back(v);
    endtask

    // One clock: model the handshake and push, step the edge, compare all outputs.
    task automatic cycle(input logic [N-1:0] spk, input logic rdy, input int push, input logic lat,
                         input int drop);
        ev_t e;
        spikes   = spk;
        ev_ready = rdy;
        if (rdy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_addr = e.addr;
            last_ts   = e.ts;
        end
        if (push >= 0) begin
            e.addr = push;
            e.ts   = exp_ts(ts_now);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        ts_now = ts_now + 16'd1;
        chk("latinhib", 32'(latinhib), 32'(lat));
        chk("drop_cnt", 32'(drop_cnt), 32'(drop));
        chk("ev_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
        chk("busy", 32'(busy), 32'(lat || exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("ev_addr", 32'(ev_addr), 32'(exp_q[0].addr));
            chk("ev_ts", 32'(ev_ts), 32'(exp_q[0].ts));
        end else begin
            chk("ev_addr_hold", 32'(ev_addr), 32'(last_addr));
            chk("ev_ts_hold", 32'(ev_ts), 32'(last_ts));
        end
    endtask

    task automatic do_reset(input int n);
        rstb     = 1'b1;
        spikes   = '1;
        ev_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rstb     = 1'b0;
        spikes   = '0;
        ev_ready = 1'b0;
        exp_q.delete();
        d         = 0;
        ts_now    = 16'd0;
        last_addr = 0;
        last_ts   = 16'd0;
        chk("rst_latinhib", 32'(latinhib), 32'd0);
        chk("rst_ev_valid", 32'(ev_valid), 32'd0);
        chk("rst_ev_addr", 32'(ev_addr), 32'd0);
        chk("rst_ev_ts", 32'(ev_ts), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        one      = N'(1);
        rstb     = 1'b1;
        spikes   = '0;
        ev_ready = 1'b0;

        // Single spike at edge 10, simultaneous spikes, spike during inhibition, exit-edge drop.
        for (int i = 0; i < 9; i++) add('0, 1'b0, -1, 1'b0, 0);
        add(one << 7, 1'b0, 7, 1'b1, 0);
        add('0, 1'b0, -1, 1'b1, 0);
        add('0, 1'b0, -1, 1'b1, 0);
        add('0, 1'b0, -1, 1'b0, 0);
        add('0, 1'b1, -1, 1'b0, 0);
        add((one << 3) | (one << 12) | (one << 20), 1'b0, 3, 1'b1, 2);
        add('0, 1'b0, -1, 1'b1, 2);
        add('0, 1'b0, -1, 1'b1, 2);
        add('0, 1'b0, -1, 1'b0, 2);
        add('0, 1'b1, -1, 1'b0, 2);
        add(one << 5, 1'b0, 5, 1'b1, 2);
        add('0, 1'b0, -1, 1'b1, 2);
        add(one << 9, 1'b0, -1, 1'b1, 3);
        add('0, 1'b0, -1, 1'b0, 3);
        add(one << 9, 1'b0, 9, 1'b1, 3);
        add('0, 1'b0, -1, 1'b1, 3);
        add('0, 1'b0, -1, 1'b1, 3);
        add(one << 1, 1'b0, -1, 1'b0, 4);
        add('0, 1'b1, -1, 1'b0, 4);
        add('0, 1'b1, -1, 1'b0, 4);
        add('0, 1'b0, -1, 1'b0, 4);

        do_reset(3);
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].spk, vecs[i].rdy, vecs[i].push, vecs[i].lat, vecs[i].drop);
        end
        d = 4;

        // FIFO full: fifth winner rejected and counted as a drop, then drain in order.
        for (int w = 0; w < 5; w++) begin
            if (w == 4) d++;
            cycle(one << (10 + w), 1'b0, (w < 4) ? (10 + w) : -1, 1'b1, d);
            cycle('0, 1'b0, -1, 1'b1, d);
            cycle('0, 1'b0, -1, 1'b1, d);
            cycle('0, 1'b0, -1, 1'b0, d);
        end
        for (int i = 0; i < 4; i++) cycle('0, 1'b1, -1, 1'b0, d);
        cycle('0, 1'b0, -1, 1'b0, d);

        // Full with simultaneous pop: push accepted, occupancy stays at DEPTH.
        for (int w = 0; w < 4; w++) begin
            cycle(one << (16 + w), 1'b0, 16 + w, 1'b1, d);
            cycle('0, 1'b0, -1, 1'b1, d);
            cycle('0, 1'b0, -1, 1'b1, d);
            cycle('0, 1'b0, -1, 1'b0, d);
        end
        cycle(one << 20, 1'b1, 20, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b0, d);
        d++;
        cycle(one << 21, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b0, d);
        for (int i = 0; i < 4; i++) cycle('0, 1'b1, -1, 1'b0, d);
        cycle('0, 1'b0, -1, 1'b0, d);

        // Reset in INHIBIT with two events queued; timestamp restarts afterwards.
        cycle(one << 22, 1'b0, 22, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b0, d);
        cycle(one << 23, 1'b0, 23, 1'b1, d);
        do_reset(1);
        cycle('0, 1'b0, -1, 1'b0, 0);
        cycle('0, 1'b0, -1, 1'b0, 0);
        cycle('0, 1'b0, -1, 1'b0, 0);
        d = 1;
        cycle((one << 2) | (one << 6), 1'b0, 2, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b0, -1, 1'b1, d);
        cycle('0, 1'b1, -1, 1'b0, d);
        cycle('0, 1'b0, -1, 1'b0, d);

        // Continuous all-ones firing with ready held high: throughput and saturation at 255.
        for (int i = 0; i < 16; i++) begin
            d = d + (((i % 4) == 0) ? 24 : 25);
            if (d > 255) d = 255;
            cycle('1, 1'b1, ((i % 4) == 0) ? 0 : -1, ((i % 4) != 3), d);
        end
        cycle('0, 1'b1, -1, 1'b0, d);
        cycle('0, 1'b0, -1, 1'b0, d);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wta_aer.md
# wta_aer

Winner-take-all arbiter and address-event encoder downstream of the integrate-and-fire neuron array. It samples the `spike` outputs of NEURONS neurons and selects one winner per firing. It drives the shared lateral-inhibition line back into every neuron's `latinhib_bus`, and queues the winner's address (plus optional timestamp) in a small FIFO with a valid/ready handshake for the readout logic.

## Interface
Parameters:
- NEURONS, 25, number of neuron spike inputs
- ADDR_W, 5, event address width; must satisfy 2^ADDR_W >= NEURONS
- DEPTH, 4, FIFO depth in events; power of two, >= 2
- INHIB_CYCLES, 3, cycles latinhib is held high per winner; must be >= 1
- TS_W, 16, timestamp width

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rstb  in  1  synchronous, active-high reset (1 = reset)
- spikes  in  NEURONS  neuron spike outputs; bit i belongs to neuron i
- latinhib  out  1  lateral inhibition to all neurons' latinhib_bus
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts the head event
- ev_addr  out  ADDR_W  neuron index of the head event
- ev_ts  out  TS_W  timestamp of the head event
- drop_cnt  out  8  count of discarded spikes, saturating at 255
- busy  out  1  high while in INHIBIT or while the FIFO is non-empty

## Operation
- Reset, while rstb=1 at a rising edge: state=IDLE, latinhib=0, FIFO empty, ev_valid=0, ev_addr=0, ev_ts=0, drop_cnt=0, timestamp counter=0, busy=0.
- Sampling: `spikes` is sampled on every rising edge. A 1 in any bit at that edge is a firing.
- Timestamp counter: increments by 1 every cycle when not in reset; wraps from 2^TS_W-1 to 0.
- State IDLE:
  - If any bit is set, the winner is the lowest set index.
  - Push {winner, current timestamp} into the FIFO.
  - Load the inhibit counter with INHIB_CYCLES-1, set latinhib=1, and go to INHIBIT.
  - Other set bits in the same sample are losers; add their popcount to drop_cnt.
- State INHIBIT:
  - latinhib=1.
  - Every set bit sampled in this state is dropped; add its popcount to drop_cnt.
  - When the counter is 0, clear latinhib and go to IDLE; otherwise decrement.
  - A spike sampled on the exit edge is dropped; it is not arbitrated.
- FIFO:
  - Registered, show-ahead. The head appears on ev_addr/ev_ts with ev_valid=1.
  - A pop occurs on an edge where ev_valid and ev_ready are both 1.
  - A push is accepted if count<DEPTH, or if a pop occurs on the same edge (full with simultaneous pop: both happen, count unchanged).
  - A rejected push (full, no pop) still enters INHIBIT, and the winner adds 1 to drop_cnt.
  - Empty FIFO: ev_valid=0; ev_addr and ev_ts hold their last values; ev_ready is ignored.
- drop_cnt adds the total drops for the cycle in one update and clamps at 255; it never wraps.
- Reset mid-operation (in INHIBIT, or FIFO non-empty) discards all events and returns every output to its reset value on that edge.

## Timing
- Spike sampled at edge k:
  - latinhib=1 after edge k, for exactly INHIB_CYCLES cycles; it drops after edge k+INHIB_CYCLES.
  - The earliest next winner is sampled at edge k+INHIB_CYCLES+1.
  - ev_valid=1 after edge k if the FIFO was empty: one-cycle latency.
- ev_ts equals the timestamp counter value before the increment at edge k.
- Sustained throughput: one event per INHIB_CYCLES+1 cycles. The consumer may hold ev_ready high continuously.
- The event at the FIFO head stays stable while ev_valid=1 and ev_ready=0.

## Configuration
- WTA_AER_TIMESTAMP_EN defined: the timestamp counter and FIFO timestamp storage are built, and ev_ts behaves as above.
- WTA_AER_TIMESTAMP_EN undefined: the counter and timestamp storage are not built, and ev_ts is tied to 0. All other behaviour is identical.

## Test plan
- Reset then single spike: spikes=1<<7 at edge 10, ev_ready=0.
  - latinhib high for 3 cycles after edge 10.
  - ev_valid=1, ev_addr=7, ev_ts=9 after edge 10.
  - drop_cnt=0.
- Simultaneous spikes: spikes bits 3, 12, 20 at one edge.
  - ev_addr=3, drop_cnt=2.
- Spike during inhibition: bit 5 at edge k, bit 9 at edge k+2.
  - One event, addr 5; drop_cnt=1.
  - Bit 9 resampled at edge k+4 gives event addr 9.
- FIFO full: ev_ready=0, five winners spaced 4 cycles apart with DEPTH=4.
  - First 4 events retained in order; drop_cnt=1.
  - Then ev_ready=1 drains them, one per cycle.
- Full with simultaneous pop: FIFO full, ev_ready=1 on the push edge.
  - Push accepted, count stays 4, drop_cnt unchanged.
- Reset mid-INHIBIT with 2 queued events: rstb=1 for one edge.
  - latinhib=0, ev_valid=0, drop_cnt=0, timestamp restarts at 0.
  - Without the macro, ev_ts stays 0 throughout all scenarios.
